// File: rtl/pe_vec.sv
// pe_vec: LANES-wide signed MAC with optional bias add and ReLU (enabled by PE_VEC_RELU_EN).
// Latency: result valid 1 cycle after the last beat, 2 cycles when bias is enabled.
// Backpressure: in_ready only while accumulating; result held until out_ready, no new config meanwhile.
module pe_vec #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   cfg_bias,
    input  logic                   cfg_relu,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*DW-1:0]    x,
    input  logic [LANES*DW-1:0]    weight,
    input  logic [LANES*ACC_W-1:0] bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] result,
    output logic                   illegal_uop
);

    if (ACC_W < 2*DW) begin : g_bad_acc_w
        $error("pe_vec: ACC_W must be at least 2*DW");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_BIAS = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                   state_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt_q;
    logic                     bias_en_q;
    logic                     illegal_q;
    logic [LANES*ACC_W-1:0]   result_q;
    logic [LANES*ACC_W-1:0]   result_d;
    logic signed [ACC_W-1:0]  acc_q    [LANES];
    logic signed [ACC_W-1:0]  mac_sum  [LANES];
    logic signed [ACC_W-1:0]  bias_sum [LANES];
    logic                     cfg_bad;
    logic                     last_beat;

`ifdef PE_VEC_RELU_EN
    logic                     relu_q;
    assign cfg_bad = (cfg_len == '0);
`else
    // Without the ReLU datapath a ReLU request cannot be honoured, so it is refused.
    assign cfg_bad = (cfg_len == '0) || cfg_relu;
`endif

    assign cfg_ready   = (state_q == S_IDLE) && !flush && !rst;
    assign in_ready    = (state_q == S_ACC) && !rst;
    assign out_valid   = (state_q == S_OUT) && !rst;
    assign illegal_uop = illegal_q && !rst;
    assign result      = result_q;
    assign last_beat   = (cnt_q == len_q - LEN_ONE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [2*DW-1:0]  prod;
        logic signed [ACC_W-1:0] fin;

        assign prod        = $signed(x[g*DW +: DW]) * $signed(weight[g*DW +: DW]);
        assign mac_sum[g]  = acc_q[g] + ACC_W'(prod);
        assign bias_sum[g] = acc_q[g] + $signed(bias[g*ACC_W +: ACC_W]);
        // The value entering OUT comes from the bias cycle or straight from the last beat.
        assign fin         = (state_q == S_BIAS) ? bias_sum[g] : mac_sum[g];
`ifdef PE_VEC_RELU_EN
        assign result_d[g*ACC_W +: ACC_W] = (relu_q && fin[ACC_W-1]) ? '0 : fin;
`else
        assign result_d[g*ACC_W +: ACC_W] = fin;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            bias_en_q <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
`ifdef PE_VEC_RELU_EN
            relu_q    <= 1'b0;
`endif
        end else begin
            illegal_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cfg_valid) begin
                            if (cfg_bad) begin
                                illegal_q <= 1'b1;
                            end else begin
                                len_q     <= cfg_len;
                                bias_en_q <= cfg_bias;
`ifdef PE_VEC_RELU_EN
                                relu_q    <= cfg_relu;
`endif
                                cnt_q     <= '0;
                                for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                                state_q   <= S_ACC;
                            end
                        end
                    end
                    S_ACC: begin
                        if (in_valid) begin
                            acc_q <= mac_sum;
                            cnt_q <= cnt_q + LEN_ONE;
                            if (last_beat) begin
                                if (bias_en_q) begin
                                    state_q <= S_BIAS;
                                end else begin
                                    result_q <= result_d;
                                    state_q  <= S_OUT;
                                end
                            end
                        end
                    end
                    S_BIAS: begin
                        acc_q    <= bias_sum;
                        result_q <= result_d;
                        state_q  <= S_OUT;
                    end
                    S_OUT: begin
                        if (out_ready) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_vec.sv
// Scoreboard bench for pe_vec: directed vectors queue expected results, a negedge monitor checks them.
module tb_pe_vec;
    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int LEN_W = 8;
    localparam int RW    = LANES*ACC_W;

    logic             clk = 1'b0;
    logic             rst, flush, cfg_valid, cfg_ready, cfg_bias, cfg_relu;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid, in_ready, out_valid, out_ready, illegal_uop;
    logic [LANES*DW-1:0] x, weight;
    logic [RW-1:0]    bias, result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pe_vec #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
        .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .weight(weight), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .illegal_uop(illegal_uop)
    );

    function automatic logic [LANES*DW-1:0] p8(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [RW-1:0] p24(input int a0, input int a1, input int a2, input int a3);
        return {24'(a3), 24'(a2), 24'(a1), 24'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_cfg(input int len, input logic b, input logic r);
        cfg_valid = 1'b1;
        cfg_len   = LEN_W'(len);
        cfg_bias  = b;
        cfg_relu  = r;
        step();
        cfg_valid = 1'b0;
        cfg_bias  = 1'b0;
        cfg_relu  = 1'b0;
    endtask

    // Monitor: every accepted result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output", result);
            end else begin
                automatic logic [RW-1:0] e = exp_q.pop_front();
                chk("result", result, e);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; cfg_valid = 1'b0; cfg_len = '0; cfg_bias = 1'b0; cfg_relu = 1'b0;
        in_valid = 1'b0; x = '0; weight = '0; bias = '0; out_ready = 1'b1;
        repeat (3) step();
        at_neg();
        chkb("rst_cfg_ready", cfg_ready, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b0);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_illegal", illegal_uop, 1'b0);
        chk("rst_result", result, '0);
        step();
        rst = 1'b0;
        at_neg();
        chkb("post_rst_cfg_ready", cfg_ready, 1'b1);

        // Three back-to-back beats, no bias.
        step();
        do_cfg(3, 1'b0, 1'b0);
        exp_q.push_back(p24(18, -105, 0, 0));
        at_neg();
        chkb("acc_in_ready", in_ready, 1'b1);
        chkb("acc_cfg_ready", cfg_ready, 1'b0);
        step();
        x = p8(2, -5, 0, 0); weight = p8(3, 7, 0, 0); in_valid = 1'b1;
        step(); step();
        at_neg();
        chkb("mid_out_valid", out_valid, 1'b0);
        step();
        in_valid = 1'b0;
        at_neg();
        chkb("lat_nobias_out_valid", out_valid, 1'b1);
        step();
        at_neg();
        chkb("after_out_cfg_ready", cfg_ready, 1'b1);
        chk("result_retained", result, p24(18, -105, 0, 0));

        // Single beat with bias: two-cycle latency.
        step();
        do_cfg(1, 1'b1, 1'b0);
        exp_q.push_back(p24(-13, 0, 0, 0));
        x = p8(-4, 0, 0, 0); weight = p8(5, 0, 0, 0); bias = p24(7, 0, 0, 0); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        at_neg();
        chkb("lat_bias_early", out_valid, 1'b0);
        step();
        at_neg();
        chkb("lat_bias_out_valid", out_valid, 1'b1);
        step();
`ifdef PE_VEC_RELU_EN
        do_cfg(1, 1'b1, 1'b1);
        exp_q.push_back(p24(0, 0, 0, 0));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
`endif

        // Bias add wrapping at the accumulator width.
        do_cfg(1, 1'b1, 1'b0);
        exp_q.push_back(p24(-8388608, 8388607, 0, 0));
        x = p8(1, -1, 0, 0); weight = p8(1, 1, 0, 0); bias = p24(8388607, -8388608, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        bias = '0;

        // Output backpressure for five cycles.
        out_ready = 1'b0;
        do_cfg(2, 1'b0, 1'b0);
        exp_q.push_back(p24(20, -40, 60, -32512));
        x = p8(1, -2, 3, -128); weight = p8(10, 10, 10, 127); in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chkb("hold_out_valid", out_valid, 1'b1);
            chk("hold_result", result, p24(20, -40, 60, -32512));
            chkb("hold_cfg_ready", cfg_ready, 1'b0);
            chkb("hold_in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        at_neg();
        chkb("release_cfg_ready", cfg_ready, 1'b1);
        chkb("release_out_valid", out_valid, 1'b0);

        // Flush after two of four beats, with a config offered during flush.
        step();
        do_cfg(4, 1'b0, 1'b0);
        x = p8(5, 5, 5, 5); weight = p8(5, 5, 5, 5); in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        flush = 1'b1; cfg_valid = 1'b1; cfg_len = 8'd1;
        at_neg();
        chkb("flush_cfg_ready", cfg_ready, 1'b0);
        step();
        flush = 1'b0; cfg_valid = 1'b0;
        at_neg();
        chkb("flush_idle_cfg_ready", cfg_ready, 1'b1);
        chkb("flush_in_ready", in_ready, 1'b0);
        chkb("flush_illegal", illegal_uop, 1'b0);
        step();
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        at_neg();
        chkb("idle_beats_illegal", illegal_uop, 1'b0);
        chkb("idle_beats_out_valid", out_valid, 1'b0);
        step();
        do_cfg(1, 1'b0, 1'b0);
        exp_q.push_back(p24(1, 0, 0, 0));
        x = p8(1, 0, 0, 0); weight = p8(1, 0, 0, 0); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();

        // Zero-length config is refused.
        cfg_valid = 1'b1; cfg_len = '0;
        at_neg();
        chkb("len0_cfg_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        at_neg();
        chkb("len0_illegal", illegal_uop, 1'b1);
        chkb("len0_cfg_ready_after", cfg_ready, 1'b1);
        chkb("len0_in_ready", in_ready, 1'b0);
        step();
        at_neg();
        chkb("len0_illegal_pulse", illegal_uop, 1'b0);
        step();
`ifndef PE_VEC_RELU_EN
        do_cfg(2, 1'b0, 1'b1);
        at_neg();
        chkb("relu_off_illegal", illegal_uop, 1'b1);
        chkb("relu_off_cfg_ready", cfg_ready, 1'b1);
        chkb("relu_off_in_ready", in_ready, 1'b0);
        step();
        at_neg();
        chkb("relu_off_illegal_pulse", illegal_uop, 1'b0);
        step();
`endif

        // Beats with gaps; operands change during gaps and must be ignored.
        do_cfg(3, 1'b0, 1'b0);
        exp_q.push_back(p24(36, -36, 30000, -30000));
        for (int k = 0; k < 3; k++) begin
            x = p8(3, -3, 100, -100); weight = p8(4, 4, 100, 100); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            x = p8(99, 99, 99, 99);
            if (k < 2) begin
                at_neg();
                chkb("gap_out_valid", out_valid, 1'b0);
                chkb("gap_in_ready", in_ready, 1'b1);
                step(); step();
            end
        end
        at_neg();
        chkb("gap_lat_out_valid", out_valid, 1'b1);
        step();

        // Reset mid-operation discards the transaction.
        do_cfg(2, 1'b0, 1'b0);
        x = p8(7, 7, 7, 7); weight = p8(7, 7, 7, 7); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        at_neg();
        chkb("midrst_in_ready", in_ready, 1'b0);
        chkb("midrst_cfg_ready", cfg_ready, 1'b0);
        step();
        rst = 1'b0;
        at_neg();
        chkb("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, '0);
        chkb("midrst_cfg_ready_after", cfg_ready, 1'b1);
        step();
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;

        repeat (3) step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
